// File: rtl/wave_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : wave_seq_checker
//  Purpose  : Receive-side monitor for the three-phase pulse waveform
//             (p1 -> p2 -> p3). It tracks the expected sequence, measures the
//             p1/p2 pulse widths, checks order, one-hot exclusivity,
//             inter-phase gaps and the p3 hold, and flags the first
//             violation with a sticky error code.
//  Ports    : clk       - single clock, all logic on posedge
//             rst       - synchronous active-high reset
//             p1/p2/p3  - phase inputs, synchronous to clk
//             seq_ok    - one-cycle pulse on entry to S_P3
//             done      - high while in S_P3
//             err       - sticky error flag
//             err_code  - first error: 0 none,1 ORDER,2 OVERLAP,3 WIDTH,
//                         4 GAP,5 DROP
//             p1_width  - p1 high cycles, latched on p1 fall
//             p2_width  - p2 high cycles, latched on p2 fall
//  Revision : 1.0 - initial release
// ============================================================================
module wave_seq_checker #(
  parameter int PULSE_CYCLES = 120,
  parameter int TOL          = 2,
  parameter int MAX_GAP      = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p1,
  input  logic             p2,
  input  logic             p3,
  output logic             seq_ok,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] p1_width,
  output logic [CNT_W-1:0] p2_width
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_P1  = 3'd1,
    GAP1  = 3'd2,
    S_P2  = 3'd3,
    GAP2  = 3'd4,
    S_P3  = 3'd5,
    S_ERR = 3'd6
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ORDER   = 3'd1;
  localparam logic [2:0] ERR_OVERLAP = 3'd2;
  localparam logic [2:0] ERR_WIDTH   = 3'd3;
  localparam logic [2:0] ERR_GAP     = 3'd4;
  localparam logic [2:0] ERR_DROP    = 3'd5;

  localparam logic [CNT_W-1:0] W_MIN   = CNT_W'(PULSE_CYCLES - TOL);
  localparam logic [CNT_W-1:0] W_MAX   = CNT_W'(PULSE_CYCLES + TOL);
  localparam logic [CNT_W-1:0] W_LIMIT = CNT_W'(PULSE_CYCLES + TOL + 1);
  localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(MAX_GAP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [2:0]       code_n;
  logic             lat_p1, lat_p2;
  logic             multi, any_hi, width_bad;

  assign multi     = (p1 & p2) | (p1 & p3) | (p2 & p3);
  assign any_hi    = p1 | p2 | p3;
  // Saturating increment: a stuck-high phase must never wrap into range.
  assign cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
  assign width_bad = (cnt < W_MIN) || (cnt > W_MAX);

  // Next-state logic. code_n != ERR_NONE means "enter S_ERR with this code";
  // the branch order inside each state encodes the error priority.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    code_n  = ERR_NONE;
    lat_p1  = 1'b0;
    lat_p2  = 1'b0;
    if (state != S_ERR && multi) begin
      code_n = ERR_OVERLAP;
      // A pulse edge still records its width even when it collides.
      lat_p1 = (state == S_P1) && !p1;
      lat_p2 = (state == S_P2) && !p2;
    end else begin
      case (state)
        IDLE: begin
          if (p1) begin
            state_n = S_P1;
            cnt_n   = CNT_ONE;
          end else if (any_hi) begin
            code_n = ERR_ORDER;
          end
        end
        S_P1: begin
          if (p1) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= W_LIMIT) code_n = ERR_WIDTH;
          end else begin
            lat_p1 = 1'b1;
            if (p3)             code_n = ERR_ORDER;
            else if (width_bad) code_n = ERR_WIDTH;
            else begin
              state_n = p2 ? S_P2 : GAP1;
              cnt_n   = CNT_ONE;
            end
          end
        end
        GAP1: begin
          if (p2) begin
            state_n = S_P2;
            cnt_n   = CNT_ONE;
          end else if (any_hi) begin
            code_n = ERR_ORDER;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc > GAP_MAX) code_n = ERR_GAP;
          end
        end
        S_P2: begin
          if (p2) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= W_LIMIT) code_n = ERR_WIDTH;
          end else begin
            lat_p2 = 1'b1;
            if (p1)             code_n = ERR_ORDER;
            else if (width_bad) code_n = ERR_WIDTH;
            else begin
              state_n = p3 ? S_P3 : GAP2;
              cnt_n   = CNT_ONE;
            end
          end
        end
        GAP2: begin
          if (p3) begin
            state_n = S_P3;
            cnt_n   = CNT_ONE;
          end else if (any_hi) begin
            code_n = ERR_ORDER;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc > GAP_MAX) code_n = ERR_GAP;
          end
        end
        S_P3: begin
          // Overlap already handled above, so anything but p3 alone is a drop.
          if (!p3) code_n = ERR_DROP;
        end
        S_ERR: begin
          state_n = S_ERR;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
    if (code_n != ERR_NONE) state_n = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      seq_ok   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      p1_width <= '0;
      p2_width <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      seq_ok <= (state_n == S_P3) && (state != S_P3);
      done   <= (state_n == S_P3);
      // code_n is only ever non-zero outside S_ERR, so the first code sticks.
      if (code_n != ERR_NONE) begin
        err      <= 1'b1;
        err_code <= code_n;
      end
      if (lat_p1) p1_width <= cnt;
      if (lat_p2) p2_width <= cnt;
    end
  end

endmodule
`default_nettype wire
